dm_stage: RTL
=============

# dm_stage

Parametrised data-memory pipeline stage for the MIPS processor, the successor to the fixed 8-bit DM block. Sits between the EX and WB stages: takes the ALU result and store data from EX, performs a load or store against an internal single-port RAM with a configurable number of wait states, and drives the write-back value. Adds a stall handshake for multi-cycle accesses and an optional parity check on stored words.

## Interface
Parameters:
- DATA_W, 8, data word width; also the width of ans_ex and ans_dm.
- ADDR_W, 8, RAM address width; depth is 2**ADDR_W; ADDR_W <= DATA_W is required.
- WAIT_CYC, 0, wait states per memory access, 0..7.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ans_ex  in  DATA_W  ALU result from EX; bits [ADDR_W-1:0] are the memory address.
- DM_data  in  DATA_W  store data.
- mem_en_ex  in  1  memory access request.
- mem_rw_ex  in  1  1 = store, 0 = load; ignored when mem_en_ex = 0.
- mem_mux_sel_dm  in  1  1 = ans_dm takes RAM read data, 0 = ans_dm takes the ALU result.
- ans_dm  out  DATA_W  registered write-back value.
- dm_stall  out  1  registered; high while an access is in progress.
- parity_err  out  1  registered, one-cycle pulse on a load parity mismatch.

## Operation
- FSM states: IDLE, BUSY. Reset state is IDLE.
- In IDLE with mem_en_ex = 0: at each edge, ans_dm <= ans_ex. No stall is raised.
- In IDLE with mem_en_ex = 1: the request is accepted at the edge. The block latches the address, DM_data, rw, and mux_sel.
  - WAIT_CYC = 0: the access completes at that same edge.
  - WAIT_CYC > 0: the FSM moves to BUSY, the wait counter loads WAIT_CYC, and dm_stall <= 1.
- In BUSY: the counter decrements each edge. Inputs are ignored, and upstream holds the next instruction while dm_stall = 1. When the counter reaches 1, the next edge completes the access, returns the FSM to IDLE, and sets dm_stall <= 0.
- Completion:
  - Store: RAM[addr] <= data. ans_dm <= latched ans_ex.
  - Load with mux_sel = 1: ans_dm <= RAM[addr].
  - Load with mux_sel = 0: ans_dm <= latched ans_ex.
- While in BUSY, ans_dm holds its value.
- Load after store to the same address returns the new data, because the store completes before the next request is accepted.
- Address wrap: only the low ADDR_W bits are used; the upper bits of ans_ex are ignored for addressing.

## Timing
- Reset values: ans_dm = 0, dm_stall = 0, parity_err = 0, FSM = IDLE, counter = 0. RAM contents are not cleared.
- Latency from the accepting edge to ans_dm valid is WAIT_CYC edges after acceptance; WAIT_CYC = 0 means the same edge.
- dm_stall is high for exactly WAIT_CYC cycles per access.
- Back-to-back accesses: the next request is accepted at the first edge where the FSM is in IDLE.
- Reset asserted mid-BUSY: the in-flight store is discarded (RAM is written only at completion), and outputs return to their reset values immediately.

## Configuration
- DM_PARITY_EN defined:
  - RAM words are DATA_W+1 bits, storing even parity on each store.
  - On load completion with a mismatch, parity_err <= 1 for one cycle. The data is still delivered.
- DM_PARITY_EN undefined: there is no parity storage and parity_err is tied to 0.

## Structure
- Package dm_pkg holds:
  - the state enum (IDLE, BUSY);
  - the default constants DM_DATA_W = 8, DM_ADDR_W = 8, DM_WAIT_MAX = 7;
  - a parity function.
- Sub-module dm_ram is a single-port synchronous RAM with a write enable, parametrised by width and depth. The FSM, counter, latches, and output mux stay in dm_stage.

## Test plan
- Reset: hold reset = 0 with ans_ex = 8'h03 -> ans_dm = 0, dm_stall = 0. Release reset with mem_en_ex = 0 -> ans_dm = 8'h03 after the next edge.
- WAIT_CYC = 0: store DM_data = 8'hFF to ans_ex = 8'h03, then load 8'h03 with mux_sel = 1 -> ans_dm = 8'hFF after one edge, dm_stall never high.
- WAIT_CYC = 3: load 8'h03 -> dm_stall high for 3 cycles, ans_dm = 8'hFF at the 3rd edge after acceptance. A changed ans_ex during the stall has no effect.
- Load with mux_sel = 0 to address 8'h03 (ans_ex = 8'h03) -> ans_dm = 8'h03, not RAM data.
- WAIT_CYC = 2: store 8'hA5 to 8'h10 and assert reset in the 1st BUSY cycle -> outputs cleared at once. A subsequent load of 8'h10 returns the old value, not 8'hA5.
- DM_PARITY_EN: store 8'h5A, then the bench flips one bit in dm_ram through a hierarchical deposit, then load -> parity_err is a one-cycle pulse, and ans_dm shows the corrupted data.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared state enum, default sizes and parity helper for the data-memory stage.
package dm_pkg;
  typedef enum logic {IDLE, BUSY} dm_state_t;
  localparam int DM_DATA_W   = 8;
  localparam int DM_ADDR_W   = 8;
  localparam int DM_WAIT_MAX = 7;
  // Zero-extension leaves the XOR reduction unchanged, so any width up to 64 fits.
  function automatic logic dm_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port RAM, synchronous write, combinational read; contents are never cleared.
module dm_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dm_stage.sv
// dm_stage: MIPS data-memory stage with wait-state FSM and stall handshake.
// Define DM_PARITY_EN to store an even-parity bit per word and flag load mismatches.
module dm_stage
  import dm_pkg::*;
#(
  parameter int DATA_W   = DM_DATA_W,
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              dm_stall,
  output logic              parity_err
);
`ifdef DM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);

  dm_state_t         r_state, w_state_nx;
  logic [2:0]        r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data, r_ans, r_ans_dm, w_ans_nx;
  logic              r_rw, r_sel, r_stall, r_perr;
  logic              w_busy, w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data, w_ans;
  logic              w_rw, w_sel, w_perr;
  logic [MEM_W-1:0]  w_wdata, w_rdata;

  // A zero-wait access completes on the accepting edge, so it uses the live inputs.
  assign w_busy = (r_state == BUSY);
  assign w_addr = w_busy ? r_addr : ans_ex[ADDR_W-1:0];
  assign w_data = w_busy ? r_data : DM_data;
  assign w_ans  = w_busy ? r_ans  : ans_ex;
  assign w_rw   = w_busy ? r_rw   : mem_rw_ex;
  assign w_sel  = w_busy ? r_sel  : mem_mux_sel_dm;
  assign w_done = w_busy ? (r_cnt == 3'd1) : (mem_en_ex && WAIT_CYC == 0);

`ifdef DM_PARITY_EN
  assign w_wdata = {dm_parity(64'(w_data)), w_data};
  assign w_perr  = dm_parity(64'(w_rdata));
`else
  assign w_wdata = w_data;
  assign w_perr  = 1'b0;
`endif

  dm_ram #(.WIDTH(MEM_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_done && w_rw),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (w_busy) begin
      w_cnt_nx = r_cnt - 3'd1;
      if (w_done) w_state_nx = IDLE;
    end else if (mem_en_ex && !w_done) begin
      w_state_nx = BUSY;
      w_cnt_nx   = WAIT_LD;
    end
    w_ans_nx = w_done ? ((!w_rw && w_sel) ? w_rdata[DATA_W-1:0] : w_ans)
             : (!w_busy && !mem_en_ex) ? ans_ex : r_ans_dm;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_ans    <= '0;
      r_rw     <= 1'b0;
      r_sel    <= 1'b0;
      r_ans_dm <= '0;
      r_stall  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_ans_dm <= w_ans_nx;
      r_stall  <= (w_state_nx == BUSY);
      r_perr   <= w_done && !w_rw && w_perr;
      if (!w_busy && mem_en_ex) begin
        r_addr <= ans_ex[ADDR_W-1:0];
        r_data <= DM_data;
        r_ans  <= ans_ex;
        r_rw   <= mem_rw_ex;
        r_sel  <= mem_mux_sel_dm;
      end
    end

  assign ans_dm     = r_ans_dm;
  assign dm_stall   = r_stall;
  assign parity_err = r_perr;
endmodule
